// File: rtl/onehot_encoder_4x2.sv
// Registered 4-to-2 one-hot encoder with valid/ready handshake and illegal-pattern counter.
// Define ONEHOT_ENC_PRIORITY_EN to resolve multi-hot patterns to their highest index.
module onehot_encoder_4x2 #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0,
    input  logic             in1,
    input  logic             in2,
    input  logic             in3,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    logic [3:0]       sel;
    logic             sel_legal;
    logic [1:0]       sel_code;
    logic             accept;

    logic [1:0]       out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    assign sel      = {in3, in2, in1, in0};
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sel_legal = 1'b0;
        sel_code  = 2'd0;
`ifdef ONEHOT_ENC_PRIORITY_EN
        sel_legal = |sel;
        if (sel[3]) begin
            sel_code = 2'd3;
        end else if (sel[2]) begin
            sel_code = 2'd2;
        end else if (sel[1]) begin
            sel_code = 2'd1;
        end else begin
            sel_code = 2'd0;
        end
`else
        case (sel)
            4'b0001: begin sel_legal = 1'b1; sel_code = 2'd0; end
            4'b0010: begin sel_legal = 1'b1; sel_code = 2'd1; end
            4'b0100: begin sel_legal = 1'b1; sel_code = 2'd2; end
            4'b1000: begin sel_legal = 1'b1; sel_code = 2'd3; end
            default: begin sel_legal = 1'b0; sel_code = 2'd0; end
        endcase
`endif
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        if (accept) begin
            if (sel_legal) begin
                out_d       = sel_code;
                out_valid_d = 1'b1;
            end else begin
                // An accepted beat implies any held code drains this cycle
                out_valid_d = 1'b0;
                err_d       = 1'b1;
                if (!(&err_count_q)) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
            end
        end else if (out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= 2'd0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule
